wb_retire_queue: RTL and testbench
==================================

// Module: wb_retire_queue
// PURPOSE
//  In-order write-back queue that owns the regfile write port and drives the
//  wbu_rdwen/wbu_rdid/wbu_rd triple seen by the regfile and the forwarding logic.
//  Retiring instructions are pushed in program order. Load entries wait for their
//  memory data; non-load entries carry their result at push time.
//  The head entry drains one write per cycle, so regfile writes stay in program order.
// PARAMETERS
//  CPU_WIDTH  64  data width of a register
//  REG_ADDRW  5   register index width
//  DEPTH      4   queue entries; power of two, >= 2
// PORTS
//  i_clk         in   1               clock
//  i_rst_n       in   1               asynchronous active-low reset
//  i_push_valid  in   1               retiring instruction offered
//  o_push_ready  out  1               queue can accept (= !full)
//  i_push_rdwen  in   1               instruction writes rd
//  i_push_lden   in   1               instruction is a load; data arrives later
//  i_push_rdid   in   REG_ADDRW       destination register
//  i_push_data   in   CPU_WIDTH       result (ignored when i_push_lden=1)
//  i_ld_valid    in   1               load data return, in load issue order
//  o_ld_ready    out  1               at least one unfilled load entry exists
//  i_ld_data     in   CPU_WIDTH       returned load data
//  o_wbu_rdwen   out  1               regfile write enable
//  o_wbu_rdid    out  REG_ADDRW       regfile write index
//  o_wbu_rd      out  CPU_WIDTH       regfile write data
//  o_count       out  $clog2(DEPTH)+1 occupied entries
//  o_empty       out  1               o_count==0
// BEHAVIOUR
//  - Reset: wr/rd/fill pointers=0, all entry valid/filled flags=0, o_wbu_*=0, o_count=0.
//    Combinational outputs after reset: o_push_ready=1, o_ld_ready=0, o_empty=1.
//    Reset mid-operation discards every entry, including unfilled loads.
//  - Entry fields: rdwen, rdid, data, filled.
//    On push: filled = !lden, data = lden ? 0 : push_data.
//  - Push fires on i_push_valid && o_push_ready and writes the entry at wr_ptr.
//    o_push_ready comes from registered state only; a same-cycle pop does not free space.
//  - Load fill: i_ld_valid && o_ld_ready writes i_ld_data into the entry at fill_ptr
//    and sets filled. fill_ptr then advances to the next load entry; it skips non-load entries.
//  - o_ld_ready comes from registered state. A load pushed in cycle N can receive data
//    from cycle N+1 onward. i_ld_valid while o_ld_ready=0 is ignored (protocol error).
//  - Pop fires when the head entry is valid and filled. The pop, a push and a fill may
//    all occur in the same cycle; o_count changes by push minus pop.
//  - A fill and a pop of the same head entry in one cycle are not allowed. A fill makes
//    the entry poppable from the next cycle.
//  - Write-back outputs are registered and updated every cycle:
//    o_wbu_rdwen <= pop && head.rdwen && (head.rdid != 0)
//    o_wbu_rdid  <= head.rdid when popping, else hold
//    o_wbu_rd    <= head.data when popping, else hold
//  - rdid==0 or rdwen=0 entries still occupy a slot and drain in order, with no write.
//  - Latency: a non-load push sampled at edge N into an empty queue pops at edge N+1.
//    o_wbu_* are valid in the cycle after N+1, and the regfile write occurs at edge N+2.
//    A load entry pops at the edge after the edge that samples its fill.
//  - Pointers wrap modulo DEPTH. full = (o_count==DEPTH).
//  - Older non-filled loads block all younger entries (head-of-line, by design).
// TESTING
//  1 Reset: assert i_rst_n=0 -> o_wbu_rdwen=0, o_count=0, o_push_ready=1, o_ld_ready=0.
//  2 Push ALU rd=5 data=0x1234 -> exactly one cycle with o_wbu_rdwen=1,
//    rdid=5, rd=0x1234, two edges after push; o_count returns to 0.
//  3 Push load rd=7, then ALU rd=8 data=0x8; stall ld 3 cycles -> no writes.
//    Then i_ld_data=0xDEAD -> write rd7=0xDEAD, next cycle rd8=0x8.
//  4 DEPTH=4 loads pushed, none filled -> o_push_ready=0, extra push refused.
//    Fill one, pop -> o_push_ready=1 the cycle after the pop.
//  5 Push rd=0 data=0xFF and push rdwen=0 -> both drain with o_wbu_rdwen=0; o_count reaches 0.
//  6 3 entries queued (1 unfilled load), assert reset -> o_count=0, o_ld_ready=0.
//    Post-reset i_ld_valid is ignored and causes no write.

Source files
------------

// File: rtl/wb_retire_queue_if.sv
// Bundle of the push, load-return and write-back signals of the in-order
// write-back queue. The master side is the pipeline/test driver and the slave
// side is the queue.
interface wb_retire_queue_if #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int DEPTH     = 4
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic                 i_push_valid;
  logic                 o_push_ready;
  logic                 i_push_rdwen;
  logic                 i_push_lden;
  logic [REG_ADDRW-1:0] i_push_rdid;
  logic [CPU_WIDTH-1:0] i_push_data;
  logic                 i_ld_valid;
  logic                 o_ld_ready;
  logic [CPU_WIDTH-1:0] i_ld_data;
  logic                 o_wbu_rdwen;
  logic [REG_ADDRW-1:0] o_wbu_rdid;
  logic [CPU_WIDTH-1:0] o_wbu_rd;
  logic [CNTW-1:0]      o_count;
  logic                 o_empty;

  modport master (
    output i_push_valid, i_push_rdwen, i_push_lden, i_push_rdid, i_push_data,
    output i_ld_valid, i_ld_data,
    input  o_push_ready, o_ld_ready, o_wbu_rdwen, o_wbu_rdid, o_wbu_rd,
    input  o_count, o_empty
  );

  modport slave (
    input  i_push_valid, i_push_rdwen, i_push_lden, i_push_rdid, i_push_data,
    input  i_ld_valid, i_ld_data,
    output o_push_ready, o_ld_ready, o_wbu_rdwen, o_wbu_rdid, o_wbu_rd,
    output o_count, o_empty
  );
endinterface

// File: rtl/wb_retire_queue.sv
// In-order write-back queue. Retiring instructions enter in program order;
// loads wait for their returned data, everything else carries its result.
// The head entry drains one regfile write per cycle once it is filled, so
// register writes stay in program order. Unfilled loads block younger entries.
module wb_retire_queue #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int DEPTH     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  wb_retire_queue_if.slave   bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_filled;
  logic [DEPTH-1:0]     r_rdwen;
  logic [REG_ADDRW-1:0] r_rdid [DEPTH];
  logic [CPU_WIDTH-1:0] r_data [DEPTH];

  // Pointers and occupancy
  logic [PTRW-1:0]      r_wr_ptr;
  logic [PTRW-1:0]      r_rd_ptr;
  logic [CNTW-1:0]      r_count;

  // Registered write-back triple
  logic                 r_wbu_rdwen;
  logic [REG_ADDRW-1:0] r_wbu_rdid;
  logic [CPU_WIDTH-1:0] r_wbu_rd;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fill;
  logic                 w_ld_ready;
  logic [PTRW-1:0]      w_fill_idx;
  logic [PTRW-1:0]      w_scan_idx;
  logic                 w_head_write;

  // Fill pointer: loads return in issue order, so the target is always the
  // oldest valid-but-unfilled entry, found by scanning from the head. This
  // skips non-load entries and already-filled loads automatically.
  always_comb begin
    w_ld_ready = 1'b0;
    w_fill_idx = r_rd_ptr;
    w_scan_idx = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = r_rd_ptr + PTRW'(i);
      if (!w_ld_ready && r_valid[w_scan_idx] && !r_filled[w_scan_idx]) begin
        w_ld_ready = 1'b1;
        w_fill_idx = w_scan_idx;
      end else begin
        w_ld_ready = w_ld_ready;
      end
    end
  end

  // Handshake decode; ready signals depend on registered state only.
  always_comb begin
    w_full       = (r_count == FULL_CNT);
    w_push       = bus.i_push_valid && !w_full;
    w_fill       = bus.i_ld_valid && w_ld_ready;
    w_pop        = r_valid[r_rd_ptr] && r_filled[r_rd_ptr];
    w_head_write = w_pop && r_rdwen[r_rd_ptr] && (r_rdid[r_rd_ptr] != {REG_ADDRW{1'b0}});
  end

  // Queue state: push at wr_ptr, fill at the oldest unfilled load, pop at head.
  // The three can never target the same entry in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= {DEPTH{1'b0}};
      r_filled <= {DEPTH{1'b0}};
      r_rdwen  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_rdid[i] <= {REG_ADDRW{1'b0}};
        r_data[i] <= {CPU_WIDTH{1'b0}};
      end
      r_wr_ptr <= {PTRW{1'b0}};
      r_rd_ptr <= {PTRW{1'b0}};
      r_count  <= {CNTW{1'b0}};
    end else begin
      if (w_push) begin
        r_valid[r_wr_ptr]  <= 1'b1;
        r_filled[r_wr_ptr] <= !bus.i_push_lden;
        r_rdwen[r_wr_ptr]  <= bus.i_push_rdwen;
        r_rdid[r_wr_ptr]   <= bus.i_push_rdid;
        r_data[r_wr_ptr]   <= bus.i_push_lden ? {CPU_WIDTH{1'b0}} : bus.i_push_data;
        r_wr_ptr           <= r_wr_ptr + {{(PTRW-1){1'b0}}, 1'b1};
      end
      if (w_fill) begin
        r_data[w_fill_idx]   <= bus.i_ld_data;
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr]  <= 1'b0;
        r_filled[r_rd_ptr] <= 1'b0;
        r_rd_ptr           <= r_rd_ptr + {{(PTRW-1){1'b0}}, 1'b1};
      end
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  // Write-back triple: enable every cycle, index/data hold between pops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wbu_rdwen <= 1'b0;
      r_wbu_rdid  <= {REG_ADDRW{1'b0}};
      r_wbu_rd    <= {CPU_WIDTH{1'b0}};
    end else begin
      r_wbu_rdwen <= w_head_write;
      if (w_pop) begin
        r_wbu_rdid <= r_rdid[r_rd_ptr];
        r_wbu_rd   <= r_data[r_rd_ptr];
      end
    end
  end

  assign bus.o_push_ready = !w_full;
  assign bus.o_ld_ready   = w_ld_ready;
  assign bus.o_wbu_rdwen  = r_wbu_rdwen;
  assign bus.o_wbu_rdid   = r_wbu_rdid;
  assign bus.o_wbu_rd     = r_wbu_rd;
  assign bus.o_count      = r_count;
  assign bus.o_empty      = (r_count == {CNTW{1'b0}});
endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: hand-computed vector table,
// directed multi-cycle sequences and random traffic against a queue model.
module tb_wb_retire_queue;
  localparam int CW = 64;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  wb_retire_queue_if #(.CPU_WIDTH(CW), .REG_ADDRW(AW), .DEPTH(DEPTH)) bus ();

  wb_retire_queue #(.CPU_WIDTH(CW), .REG_ADDRW(AW), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: a plain queue of entries ----------------
  typedef struct {
    logic          rdwen;
    logic [AW-1:0] rdid;
    logic [CW-1:0] data;
    logic          filled;
  } ent_t;

  ent_t          mq[$];
  logic          m_wen;
  logic [AW-1:0] m_rdid;
  logic [CW-1:0] m_rd;

  typedef struct {
    logic          pv, wen, ld;
    logic [AW-1:0] rdid;
    logic [CW-1:0] data;
    logic          lv;
    logic [CW-1:0] ldata;
    logic          e_wen;
    logic [AW-1:0] e_rdid;
    logic [CW-1:0] e_rd;
    int            e_cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_unfilled();
    int fi;
    fi = -1;
    for (int i = 0; i < mq.size(); i++)
      if (fi < 0 && !mq[i].filled) fi = i;
    return fi;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wen  = 1'b0;
    m_rdid = '0;
    m_rd   = '0;
  endtask

  // One clock: drive at the low phase, check readies, update the model for
  // the coming edge, then check registered outputs after the edge.
  task automatic step(input logic pv, input logic wen, input logic ld,
                      input logic [AW-1:0] rdid, input logic [CW-1:0] data,
                      input logic lv, input logic [CW-1:0] ldata);
    int   fi;
    logic prdy, lrdy;
    ent_t e;
    bus.i_push_valid = pv;
    bus.i_push_rdwen = wen;
    bus.i_push_lden  = ld;
    bus.i_push_rdid  = rdid;
    bus.i_push_data  = data;
    bus.i_ld_valid   = lv;
    bus.i_ld_data    = ldata;
    #1;
    fi   = first_unfilled();
    lrdy = (fi >= 0);
    prdy = (mq.size() < DEPTH);
    chk("push_ready", {63'd0, bus.o_push_ready}, {63'd0, prdy});
    chk("ld_ready", {63'd0, bus.o_ld_ready}, {63'd0, lrdy});
    if (mq.size() > 0 && mq[0].filled) begin
      m_wen  = mq[0].rdwen && (mq[0].rdid != 5'd0);
      m_rdid = mq[0].rdid;
      m_rd   = mq[0].data;
      mq.pop_front();
      fi = fi - 1;
    end else begin
      m_wen = 1'b0;
    end
    if (lv && lrdy) begin
      e = mq[fi];
      e.data = ldata;
      e.filled = 1'b1;
      mq[fi] = e;
    end
    if (pv && prdy) begin
      e.rdwen  = wen;
      e.rdid   = rdid;
      e.data   = ld ? 64'd0 : data;
      e.filled = !ld;
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("wbu_rdwen", {63'd0, bus.o_wbu_rdwen}, {63'd0, m_wen});
    chk("wbu_rdid", {59'd0, bus.o_wbu_rdid}, {59'd0, m_rdid});
    chk("wbu_rd", bus.o_wbu_rd, m_rd);
    chk("count", {61'd0, bus.o_count}, 64'(mq.size()));
    chk("empty", {63'd0, bus.o_empty}, {63'd0, (mq.size() == 0)});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
  endtask

  function automatic vec_t mk(input logic pv, input logic wen, input logic ld,
                              input logic [AW-1:0] rdid, input logic [CW-1:0] data,
                              input logic lv, input logic [CW-1:0] ldata,
                              input logic e_wen, input logic [AW-1:0] e_rdid,
                              input logic [CW-1:0] e_rd, input int e_cnt);
    vec_t v;
    v.pv = pv; v.wen = wen; v.ld = ld; v.rdid = rdid; v.data = data;
    v.lv = lv; v.ldata = ldata;
    v.e_wen = e_wen; v.e_rdid = e_rdid; v.e_rd = e_rd; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst_n = 1'b0;
    bus.i_push_valid = 1'b0; bus.i_push_rdwen = 1'b0; bus.i_push_lden = 1'b0;
    bus.i_push_rdid = 5'd0; bus.i_push_data = 64'd0;
    bus.i_ld_valid = 1'b0; bus.i_ld_data = 64'd0;

    // Expected results after each vector's clock edge, worked out by hand.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      1);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b1, 5'd5, 64'h1234,   0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 5'd7, 64'h77,   1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      1);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 5'd8, 64'h8,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      2);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      2);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      2);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      2);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b1, 64'hDEAD,   1'b0, 5'd0, 64'd0,      2);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b1, 5'd7, 64'hDEAD,   1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b1, 5'd8, 64'h8,      0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      0);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 5'd0, 64'hFF,   1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      1);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 5'd3, 64'h55,   1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      0);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0,    1'b0, 64'd0,      1'b0, 5'd0, 64'd0,      0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_wbu_rdwen", {63'd0, bus.o_wbu_rdwen}, 64'd0);
    chk("rst_count", {61'd0, bus.o_count}, 64'd0);
    chk("rst_push_ready", {63'd0, bus.o_push_ready}, 64'd1);
    chk("rst_ld_ready", {63'd0, bus.o_ld_ready}, 64'd0);
    chk("rst_empty", {63'd0, bus.o_empty}, 64'd1);
    rst_n = 1'b1;

    // Table: single ALU write, load stall then in-order drain, rd0/rdwen0 drain
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].pv, tbl[k].wen, tbl[k].ld, tbl[k].rdid, tbl[k].data, tbl[k].lv, tbl[k].ldata);
      chk($sformatf("tbl%0d_wen", k), {63'd0, bus.o_wbu_rdwen}, {63'd0, tbl[k].e_wen});
      chk($sformatf("tbl%0d_cnt", k), {61'd0, bus.o_count}, 64'(tbl[k].e_cnt));
      if (tbl[k].e_wen) begin
        chk($sformatf("tbl%0d_rdid", k), {59'd0, bus.o_wbu_rdid}, {59'd0, tbl[k].e_rdid});
        chk($sformatf("tbl%0d_rd", k), bus.o_wbu_rd, tbl[k].e_rd);
      end
    end

    // Full of unfilled loads: refuse push, free a slot only after the pop
    for (int k = 1; k <= DEPTH; k++)
      step(1'b1, 1'b1, 1'b1, AW'(k), 64'd0, 1'b0, 64'd0);
    chk("full_push_ready", {63'd0, bus.o_push_ready}, 64'd0);
    step(1'b1, 1'b1, 1'b0, 5'd9, 64'h99, 1'b0, 64'd0);
    chk("full_refused_cnt", {61'd0, bus.o_count}, 64'd4);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'hA1);
    chk("fill_still_full", {63'd0, bus.o_push_ready}, 64'd0);
    idle();
    chk("pop_rd1_wen", {63'd0, bus.o_wbu_rdwen}, 64'd1);
    chk("pop_rd1_data", bus.o_wbu_rd, 64'hA1);
    chk("after_pop_ready", {63'd0, bus.o_push_ready}, 64'd1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'hB2);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'hB3);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'hB4);
    for (int k = 0; k < 4; k++) idle();

    // Reset with entries queued, including an unfilled load
    step(1'b1, 1'b1, 1'b1, 5'd10, 64'd0, 1'b0, 64'd0);
    step(1'b1, 1'b1, 1'b0, 5'd11, 64'h11, 1'b0, 64'd0);
    step(1'b1, 1'b1, 1'b0, 5'd12, 64'h12, 1'b0, 64'd0);
    chk("pre_rst_cnt", {61'd0, bus.o_count}, 64'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_count", {61'd0, bus.o_count}, 64'd0);
    chk("midrst_ld_ready", {63'd0, bus.o_ld_ready}, 64'd0);
    chk("midrst_push_ready", {63'd0, bus.o_push_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'hBEEF);
    chk("post_rst_ld_nowrite", {63'd0, bus.o_wbu_rdwen}, 64'd0);
    idle();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 2) == 0),
           AW'($urandom), {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom});
    end
    for (int k = 0; k < 12; k++)
      step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, {$urandom, $urandom});
    chk("final_empty", {63'd0, bus.o_empty}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
